// File: rtl/kv_pkg.sv
// Shared encodings between the request master and the key-value store.
// Both sides import this so the op/status codes cannot drift apart.
package kv_pkg;

  localparam int KEY_BITS   = 32;
  localparam int TIMER_BITS = 16;
  localparam int RETRY_BITS = 4;

  typedef enum logic [1:0] {
    OP_SEARCH   = 2'd0,
    OP_INSERT   = 2'd1,
    OP_TRANSACT = 2'd2,
    OP_ILLEGAL  = 2'd3
  } kv_op_e;

  typedef enum logic [1:0] {
    STS_OK        = 2'd0,
    STS_NOT_FOUND = 2'd1,
    STS_TIMEOUT   = 2'd2,
    STS_BAD_OP    = 2'd3
  } kv_status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_RESP  = 2'd3
  } kv_state_e;

endpackage

// File: rtl/kv_timeout_ctr.sv
// Per-attempt timeout counter: counts while run is high, clears otherwise.
// expired is high on the LIMIT-th consecutive run cycle.
module kv_timeout_ctr
  import kv_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic expired
);

  logic [TIMER_BITS-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (run) begin
      count <= count + 16'd1;
    end else begin
      count <= '0;
    end
  end

  assign expired = run && (count == TIMER_BITS'(LIMIT - 1));

endmodule

// File: rtl/kv_request_master.sv
// Initiator for the key-value store: takes host commands, drives req/ack
// with per-attempt timeout and bounded retry, returns one response each.
module kv_request_master
  import kv_pkg::*;
#(
  parameter int ADDR_BITS      = 9,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRY      = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [31:0]          cmd_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic [ADDR_BITS-1:0] rsp_addr,
  output logic                 kv_req,
  output logic [1:0]           kv_op,
  output logic [31:0]          kv_key,
  input  logic                 kv_ack,
  input  logic                 kv_found,
  input  logic [ADDR_BITS-1:0] kv_value_addr
);

  kv_state_e             state, state_nxt;
  logic [1:0]            op_q, op_nxt;
  logic [KEY_BITS-1:0]   key_q, key_nxt;
  logic [RETRY_BITS-1:0] attempt_q, attempt_nxt;
  logic [1:0]            status_q, status_nxt;
  logic [ADDR_BITS-1:0]  addr_q, addr_nxt;
  logic                  timer_expired;

  kv_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .run    (state == S_ISSUE),
    .expired(timer_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      key_q     <= '0;
      attempt_q <= '0;
      status_q  <= '0;
      addr_q    <= '0;
    end else begin
      state     <= state_nxt;
      op_q      <= op_nxt;
      key_q     <= key_nxt;
      attempt_q <= attempt_nxt;
      status_q  <= status_nxt;
      addr_q    <= addr_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt   = state;
    op_nxt      = op_q;
    key_nxt     = key_q;
    attempt_nxt = attempt_q;
    status_nxt  = status_q;
    addr_nxt    = addr_q;

    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_nxt      = cmd_op;
          key_nxt     = cmd_key;
          attempt_nxt = '0;
          if (cmd_op == OP_ILLEGAL) begin
            status_nxt = STS_BAD_OP;
            addr_nxt   = '0;
            state_nxt  = S_RESP;
          end else begin
            state_nxt  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Ack is checked before expiry so a same-cycle ack still completes the command.
        if (kv_ack) begin
          status_nxt = kv_found ? STS_OK : STS_NOT_FOUND;
          addr_nxt   = kv_found ? kv_value_addr : '0;
          state_nxt  = S_RESP;
        end else if (timer_expired) begin
          if (attempt_q < RETRY_BITS'(MAX_RETRY)) begin
            attempt_nxt = attempt_q + 4'd1;
            state_nxt   = S_GAP;
          end else begin
            status_nxt = STS_TIMEOUT;
            addr_nxt   = '0;
            state_nxt  = S_RESP;
          end
        end
      end
      S_GAP: begin
        state_nxt = S_ISSUE;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign kv_req     = (state == S_ISSUE);
  assign rsp_status = status_q;
  assign rsp_addr   = addr_q;
  assign kv_op      = op_q;
  assign kv_key     = key_q;

endmodule

// File: doc/kv_request_master.md
# kv_request_master

Initiator side of the key-value store command interface. Accepts host operations (search, insert, transact) over a valid/ready channel and drives them onto the store's request/acknowledge port. Applies a per-attempt timeout with bounded retry, then returns one status/address response per command. Sits between the transaction front-end and the hashed BRAM key-value store.

## Interface
- `ADDR_BITS`, 9: width of value address returned by the store.
- `TIMEOUT_CYCLES`, 64: cycles to wait for `kv_ack` per attempt, 1..65535.
- `MAX_RETRY`, 2: extra attempts after first timeout, 0..15.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: host command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: 0 search, 1 insert, 2 transact, 3 illegal.
- `cmd_key` in 32: key.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: host consumes response.
- `rsp_status` out 2: 0 OK, 1 NOT_FOUND, 2 TIMEOUT, 3 BAD_OP.
- `rsp_addr` out ADDR_BITS: value address from the store; 0 unless status OK.
- `kv_req` out 1: request to store, held until ack.
- `kv_op` out 2: op to store, matches `signal` encoding.
- `kv_key` out 32: key to store.
- `kv_ack` in 1: store completion strobe, single cycle.
- `kv_found` in 1: valid with `kv_ack`; key hit / insert succeeded.
- `kv_value_addr` in ADDR_BITS: valid with `kv_ack`.

## Operation
- FSM states: IDLE, ISSUE, GAP, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch op/key.
  - op==3 goes directly to RESP with BAD_OP; nothing issued.
  - Otherwise goes to ISSUE with attempt=0 and timer=0.
- ISSUE: `kv_req`=1; `kv_op`/`kv_key` stable from latch; timer increments each cycle.
  - `kv_ack`=1 goes to RESP with status OK and `rsp_addr`=`kv_value_addr` if `kv_found`, else NOT_FOUND with `rsp_addr`=0.
  - Timer reaching TIMEOUT_CYCLES without ack:
    - If attempt<MAX_RETRY: attempt+1, go to GAP.
    - Else go to RESP with TIMEOUT.
- GAP: one cycle with `kv_req`=0 (store sees fresh rising request), timer cleared, then back to ISSUE.
- RESP: `rsp_valid`=1; outputs stable until `rsp_ready`, then to IDLE.
- `kv_ack` outside ISSUE is ignored (late ack after timeout is discarded).
- Ack on the same cycle as timer expiry: ack wins.
- `kv_op`/`kv_key` hold last latched value outside ISSUE; `kv_req` low.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, `cmd_ready`=1.
  - `rsp_valid`=0, `rsp_status`=0, `rsp_addr`=0.
  - `kv_req`=0, `kv_op`=0, `kv_key`=0.
  - timer=0, attempt=0.
- Accept cycle N puts `kv_req` high at N+1. Ack at N+k puts `rsp_valid` high at N+k+1.
- Minimum command-to-response latency is 2 cycles. BAD_OP gives `rsp_valid` at N+1.
- An attempt lasts exactly TIMEOUT_CYCLES cycles of `kv_req` high. Worst case to TIMEOUT response: (MAX_RETRY+1)·TIMEOUT_CYCLES + MAX_RETRY + 1 cycles after accept.
- `rsp_ready` held high at RESP entry gives one response cycle; `cmd_ready` returns the next cycle. Throughput is at most one command per 3 cycles.
- Reset mid-ISSUE drops `kv_req` immediately; the pending command is lost with no response.
- Timer is 16 bits; attempt counter is 4 bits; both saturate-free within parameter ranges.

## Structure
- Shared package `kv_pkg`: op encodings (OP_SEARCH=0, OP_INSERT=1, OP_TRANSACT=2), status encodings, FSM state enum.
- Package is shared with the store so both sides use one `signal`/`kv_op` encoding.
- Single module, no sub-module. The timeout timer may be a small `kv_timeout_ctr` sub-module if reused by the store side.

## Test plan
- Search hit: cmd op=0 key=0x0000_00A5; store acks after 3 cycles with found=1, addr=0x012 -> response OK, `rsp_addr`=0x012, `rsp_valid` 4 cycles after accept.
- Insert miss: op=1 key=0xDEAD_BEEF; ack found=0 -> NOT_FOUND, `rsp_addr`=0. `kv_req` deasserts the cycle after ack.
- Timeout with retry: TIMEOUT_CYCLES=4, MAX_RETRY=2, no ack -> three 4-cycle `kv_req` pulses separated by 1 low cycle, then TIMEOUT. A late ack during GAP is ignored.
- Retry success: same params, ack on second attempt cycle 2 with addr=0x1FF -> OK, 0x1FF.
- Illegal op 3 -> BAD_OP at next cycle, `kv_req` never asserts. Backpressure: `rsp_ready` low for 5 cycles -> response stable, `cmd_ready`=0 throughout.
- Reset asserted mid-ISSUE -> `kv_req`, `rsp_valid` low asynchronously. After release, the next command completes normally.
